alu_mc: RTL and testbench

Parametrised, multi-cycle successor to the 16-bit core ALU. Width is generic. Operands enter through a valid/ready handshake and results leave through one. Results and flags are registered. The block adds an iterative unsigned multiply (op 7, previously reserved) and a sticky flag register that the branch logic reads. It sits between operand fetch and register writeback in the core datapath.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_comb.sv | 73 +++++++
 rtl/alu_mc.sv | 133 +++++++++++++
 tb/tb_alu_mc.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: op codes, FSM states and the
// bit positions of the sticky flag register.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_CMP = 4'd5;
    localparam logic [3:0] OP_MOV = 4'd6;
    localparam logic [3:0] OP_MUL = 4'd7;
    localparam logic [3:0] OP_SLL = 4'd8;
    localparam logic [3:0] OP_SLR = 4'd9;
    localparam logic [3:0] OP_SRL = 4'd10;
    localparam logic [3:0] OP_SRA = 4'd11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam int FLAG_S = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_comb.sv
// Single-cycle datapath for every op except MUL, with S/Z/C/V generation.
module alu_comb
    import alu_pkg::*;
#(
    parameter int W   = 16,
    parameter int SHW = $clog2(W)
) (
    input  logic [3:0]     op,
    input  logic [SHW-1:0] shamt,
    input  logic [W-1:0]   data1,
    input  logic [W-1:0]   data2,
    output logic [W-1:0]   res,
    output logic           s,
    output logic           z,
    output logic           c,
    output logic           v
);

    logic [W:0]     sum;
    logic [W:0]     diff;
    logic [W:0]     sll_ext;
    logic [W:0]     srl_ext;
    logic [W:0]     sra_ext;
    logic [2*W-1:0] rot;

    assign sum     = {1'b0, data2} + {1'b0, data1};
    assign diff    = {1'b0, data2} - {1'b0, data1};
    // The extra bit beyond the result catches the last bit shifted out,
    // which is zero automatically when shamt is zero.
    assign sll_ext = {1'b0, data2} << shamt;
    assign srl_ext = {data2, 1'b0} >> shamt;
    assign sra_ext = $signed({data2, 1'b0}) >>> shamt;
    assign rot     = {data2, data2} << shamt;

    always_comb begin
        res = '0;
        c   = 1'b0;
        v   = 1'b0;
        case (op)
            OP_ADD: begin
                res = sum[W-1:0];
                c   = sum[W];
                v   = (data2[W-1] == data1[W-1]) && (sum[W-1] != data2[W-1]);
            end
            OP_SUB, OP_CMP: begin
                res = diff[W-1:0];
                c   = diff[W];
                v   = (data2[W-1] != data1[W-1]) && (diff[W-1] != data2[W-1]);
            end
            OP_AND: res = data2 & data1;
            OP_OR:  res = data2 | data1;
            OP_XOR: res = data2 ^ data1;
            OP_MOV: res = data1;
            OP_SLL: begin
                res = sll_ext[W-1:0];
                c   = sll_ext[W];
            end
            OP_SLR: res = rot[2*W-1:W];
            OP_SRL: begin
                res = srl_ext[W:1];
                c   = srl_ext[0];
            end
            OP_SRA: begin
                res = sra_ext[W:1];
                c   = sra_ext[0];
            end
            default: res = '0;
        endcase
        s = res[W-1];
        z = (res == '0);
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: handshaked operands, registered result/flags, iterative
// shift-add multiply and a sticky flag register updated on consume.
module alu_mc
    import alu_pkg::*;
#(
    parameter int W   = 16,
    parameter int SHW = $clog2(W)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [3:0]     op,
    input  logic [SHW-1:0] shamt,
    input  logic [W-1:0]   data1,
    input  logic [W-1:0]   data2,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   res,
    output logic           S,
    output logic           Z,
    output logic           C,
    output logic           V,
    output logic [3:0]     flags
);

    state_t         state_q, state_d;
    logic [W-1:0]   res_q;
    logic           s_q, z_q, c_q, v_q;
    logic [3:0]     flags_q;
    logic [2*W-1:0] acc_q, acc_d;
    logic [2*W-1:0] mcand_q;
    logic [W-1:0]   mplier_q;
    logic [SHW-1:0] cnt_q;

    logic [W-1:0]   comb_res;
    logic           comb_s, comb_z, comb_c, comb_v;
    logic           accept, consume, mul_last;
    logic [W-1:0]   prod_lo;
    logic           prod_hi_nz;

    alu_comb #(.W(W), .SHW(SHW)) u_comb (
        .op    (op),
        .shamt (shamt),
        .data1 (data1),
        .data2 (data2),
        .res   (comb_res),
        .s     (comb_s),
        .z     (comb_z),
        .c     (comb_c),
        .v     (comb_v)
    );

    assign in_ready   = (state_q == ST_IDLE) || ((state_q == ST_HOLD) && out_ready);
    assign out_valid  = (state_q == ST_HOLD);
    assign accept     = in_valid && in_ready;
    assign consume    = out_valid && out_ready;
    assign mul_last   = (state_q == ST_MUL) && (cnt_q == SHW'(W - 1));
    assign acc_d      = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign prod_lo    = acc_d[W-1:0];
    assign prod_hi_nz = |acc_d[2*W-1:W];

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = (op == OP_MUL) ? ST_MUL : ST_HOLD;
            ST_MUL:  if (mul_last) state_d = ST_HOLD;
            ST_HOLD: begin
                if (accept)       state_d = (op == OP_MUL) ? ST_MUL : ST_HOLD;
                else if (consume) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            res_q    <= '0;
            s_q      <= 1'b0;
            z_q      <= 1'b0;
            c_q      <= 1'b0;
            v_q      <= 1'b0;
            flags_q  <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q <= state_d;
            if (consume) begin
                flags_q[FLAG_S] <= s_q;
                flags_q[FLAG_Z] <= z_q;
                flags_q[FLAG_C] <= c_q;
                flags_q[FLAG_V] <= v_q;
            end
            if (accept && (op == OP_MUL)) begin
                mcand_q  <= {{W{1'b0}}, data2};
                mplier_q <= data1;
                acc_q    <= '0;
                cnt_q    <= '0;
            end else if (accept) begin
                res_q <= comb_res;
                s_q   <= comb_s;
                z_q   <= comb_z;
                c_q   <= comb_c;
                v_q   <= comb_v;
            end
            // One partial product per cycle; the last step's sum is the product.
            if (state_q == ST_MUL) begin
                acc_q    <= acc_d;
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                cnt_q    <= cnt_q + SHW'(1);
                if (mul_last) begin
                    res_q <= prod_lo;
                    s_q   <= prod_lo[W-1];
                    z_q   <= (prod_lo == '0);
                    c_q   <= prod_hi_nz;
                    v_q   <= prod_hi_nz;
                end
            end
        end
    end

    assign res   = res_q;
    assign S     = s_q;
    assign Z     = z_q;
    assign C     = c_q;
    assign V     = v_q;
    assign flags = flags_q;

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc at W=16 with hand-computed expected values.
module tb_alu_mc;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op;
    logic [3:0]  shamt;
    logic [15:0] data1;
    logic [15:0] data2;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] res;
    logic        S, Z, C, V;
    logic [3:0]  flags;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_mc #(.W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .shamt     (shamt),
        .data1     (data1),
        .data2     (data2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res),
        .S         (S),
        .Z         (Z),
        .C         (C),
        .V         (V),
        .flags     (flags)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %-14s observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic drive(input logic v, input logic [3:0] o, input logic [3:0] sh,
                         input logic [15:0] d2, input logic [15:0] d1);
        in_valid = v;
        op       = o;
        shamt    = sh;
        data2    = d2;
        data1    = d1;
    endtask

    initial begin
        rst = 1'b1;
        out_ready = 1'b1;
        drive(1'b0, 4'd0, 4'd0, 16'h0, 16'h0);
        tick();
        tick();
        rst = 1'b0;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready",  {31'd0, in_ready}, 32'd1);
        chk("rst_res",       {16'd0, res}, 32'd0);
        chk("rst_szcv",      {28'd0, S, Z, C, V}, 32'd0);
        chk("rst_flags",     {28'd0, flags}, 32'd0);

        // ADD overflow into the sign bit
        drive(1'b1, 4'd0, 4'd0, 16'h7FFF, 16'h0001);
        tick();
        drive(1'b0, 4'd0, 4'd0, 16'h0, 16'h0);
        chk("add_valid", {31'd0, out_valid}, 32'd1);
        chk("add_res",   {16'd0, res}, 32'h8000);
        chk("add_szcv",  {28'd0, S, Z, C, V}, 32'b1001);
        chk("add_flags_pre", {28'd0, flags}, 32'd0);
        tick();
        chk("add_flags", {28'd0, flags}, 32'b1001);
        chk("add_idle",  {31'd0, out_valid}, 32'd0);

        // SUB borrow, then back-to-back CMP of equal operands
        drive(1'b1, 4'd1, 4'd0, 16'h0000, 16'h0001);
        tick();
        chk("sub_res",  {16'd0, res}, 32'hFFFF);
        chk("sub_szcv", {28'd0, S, Z, C, V}, 32'b1010);
        drive(1'b1, 4'd5, 4'd0, 16'h1234, 16'h1234);
        tick();
        drive(1'b0, 4'd0, 4'd0, 16'h0, 16'h0);
        chk("cmp_valid", {31'd0, out_valid}, 32'd1);
        chk("cmp_res",   {16'd0, res}, 32'h0000);
        chk("cmp_szcv",  {28'd0, S, Z, C, V}, 32'b0100);
        chk("sub_flags", {28'd0, flags}, 32'b1010);
        tick();
        chk("cmp_flags", {28'd0, flags}, 32'b0100);

        // Shifts on 0x8001, issued back-to-back
        drive(1'b1, 4'd11, 4'd1, 16'h8001, 16'h0);
        tick();
        chk("sra_res", {16'd0, res}, 32'hC000);
        chk("sra_c",   {31'd0, C}, 32'd1);
        drive(1'b1, 4'd9, 4'd4, 16'h8001, 16'h0);
        tick();
        chk("slr_res", {16'd0, res}, 32'h0018);
        chk("slr_c",   {31'd0, C}, 32'd0);
        drive(1'b1, 4'd8, 4'd0, 16'h8001, 16'h0);
        tick();
        chk("sll0_res", {16'd0, res}, 32'h8001);
        chk("sll0_c",   {31'd0, C}, 32'd0);
        drive(1'b1, 4'd8, 4'd1, 16'h8001, 16'h0);
        tick();
        chk("sll1_res", {16'd0, res}, 32'h0002);
        chk("sll1_c",   {31'd0, C}, 32'd1);
        drive(1'b1, 4'd10, 4'd1, 16'h8001, 16'h0);
        tick();
        chk("srl_res", {16'd0, res}, 32'h4000);
        chk("srl_c",   {31'd0, C}, 32'd1);
        drive(1'b1, 4'd13, 4'd0, 16'hFFFF, 16'hFFFF);
        tick();
        chk("op13_res",  {16'd0, res}, 32'h0000);
        chk("op13_szcv", {28'd0, S, Z, C, V}, 32'b0100);
        drive(1'b0, 4'd0, 4'd0, 16'h0, 16'h0);
        tick();

        // MUL with in_valid held high for a queued ADD
        drive(1'b1, 4'd7, 4'd0, 16'h0100, 16'h0100);
        tick();
        drive(1'b1, 4'd0, 4'd0, 16'h0001, 16'h0002);
        for (int i = 1; i < 16; i++) begin
            tick();
            chk($sformatf("mul_wait%0d", i), {30'd0, out_valid, in_ready}, 32'b00);
        end
        tick();
        chk("mul_valid", {31'd0, out_valid}, 32'd1);
        chk("mul_res",   {16'd0, res}, 32'h0000);
        chk("mul_szcv",  {28'd0, S, Z, C, V}, 32'b0111);
        tick();
        drive(1'b0, 4'd0, 4'd0, 16'h0, 16'h0);
        chk("mul_flags", {28'd0, flags}, 32'b0111);
        chk("b2b_res",   {16'd0, res}, 32'h0003);
        chk("b2b_valid", {31'd0, out_valid}, 32'd1);
        tick();
        chk("b2b_flags", {28'd0, flags}, 32'b0000);

        // Backpressure on an XOR result
        out_ready = 1'b0;
        drive(1'b1, 4'd4, 4'd0, 16'hF0F0, 16'h0F00);
        tick();
        drive(1'b1, 4'd2, 4'd0, 16'hFFFF, 16'h8234);
        chk("xor_res", {16'd0, res}, 32'hFFF0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("bp_res%0d", i),  {16'd0, res}, 32'hFFF0);
            chk($sformatf("bp_ctl%0d", i),  {28'd0, out_valid, in_ready, S, Z}, 32'b1010);
            chk($sformatf("bp_flag%0d", i), {28'd0, flags}, 32'b0000);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_rdy", {31'd0, in_ready}, 32'd1);
        tick();
        drive(1'b0, 4'd0, 4'd0, 16'h0, 16'h0);
        chk("and_res",   {16'd0, res}, 32'h8234);
        chk("xor_flags", {28'd0, flags}, 32'b1000);
        tick();
        chk("and_flags", {28'd0, flags}, 32'b1000);

        // Reset in the middle of a MUL
        drive(1'b1, 4'd7, 4'd0, 16'h0003, 16'h0005);
        tick();
        drive(1'b0, 4'd0, 4'd0, 16'h0, 16'h0);
        for (int i = 1; i < 8; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_ctl",   {30'd0, out_valid, in_ready}, 32'b01);
        chk("mrst_flags", {28'd0, flags}, 32'd0);
        chk("mrst_res",   {16'd0, res}, 32'd0);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk($sformatf("mrst_quiet%0d", i), {31'd0, out_valid}, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
